mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 28 ++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared processor definitions for the multiply/divide unit: op codes, FSM
// state encodings and the operand magnitude helper.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'b00,
    MDU_RUN    = 2'b01,
    MDU_FINISH = 2'b10
  } mdu_state_e;

  // Absolute value for signed ops; 32'h80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[MDU_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, then one sign-fix cycle that writes HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  mdu_state_e             r_state;
  logic [MDU_CNT_W-1:0]   r_count;
  logic                   r_fix;
  logic [1:0]             r_op;
  logic                   r_sign_a;
  logic                   r_sign_b;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_opnd;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_signed_in;
  logic [WIDTH-1:0]       w_mag_a;
  logic [WIDTH-1:0]       w_mag_b;
  logic [WIDTH:0]         w_sum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_rem_sh;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_diff;
  logic [2*WIDTH-1:0]     w_div_next;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic                   w_signed;
  logic                   w_neg_q;
  logic                   w_neg_r;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quot;
  logic [WIDTH-1:0]       w_rem;
  logic [WIDTH-1:0]       w_hi_res;
  logic [WIDTH-1:0]       w_lo_res;

  assign w_signed_in = ~op[0];
  assign w_mag_a     = mdu_mag(operand_a, w_signed_in);
  assign w_mag_b     = mdu_mag(operand_b, w_signed_in);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient in}.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_acc_next = r_op[1] ? w_div_next : w_mul_next;

  // A zero divisor keeps the all-ones quotient unsigned so both DIV and DIVU
  // return lo = all ones and hi = dividend.
  assign w_signed = ~r_op[0];
  assign w_neg_q  = w_signed & (r_sign_a ^ r_sign_b) & (~r_op[1] | (r_opnd != '0));
  assign w_neg_r  = w_signed & r_sign_a & r_op[1];
  assign w_prod   = w_neg_q ? -r_acc : r_acc;
  assign w_quot   = w_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = w_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_hi_res = r_op[1] ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_op[1] ? w_quot : w_prod[WIDTH-1:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= MDU_IDLE;
      r_count  <= '0;
      r_fix    <= 1'b0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= MDU_RUN;
            r_busy   <= 1'b1;
            r_count  <= MDU_CNT_W'(WIDTH-1);
            r_fix    <= 1'b0;
            r_op     <= op;
            r_sign_a <= operand_a[WIDTH-1];
            r_sign_b <= operand_b[WIDTH-1];
            if (op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
              r_opnd <= w_mag_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
              r_opnd <= w_mag_a;
            end
          end else begin
            if (mthi) r_hi <= write_data;
            if (mtlo) r_lo <= write_data;
          end
        end
        MDU_RUN: begin
          // 32 iteration cycles, then one cycle that sign-corrects into HI/LO.
          if (!r_fix) begin
            r_acc <= w_acc_next;
            if (r_count == '0) r_fix <= 1'b1;
            else               r_count <= r_count - MDU_CNT_W'(1);
          end else begin
            r_fix   <= 1'b0;
            r_hi    <= w_hi_res;
            r_lo    <= w_lo_res;
            r_done  <= 1'b1;
            r_state <= MDU_FINISH;
          end
        end
        MDU_FINISH: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= MDU_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_fix   <= 1'b0;
          r_state <= MDU_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit: latency, HI/LO results,
// move instructions, ignored inputs while busy and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks;
  int          errors;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .o_dbg_state(dbg_state)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi,lo} from plain language arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    int sa;
    int sb;
    pa = $signed({{32{a[31]}}, a});
    pb = $signed({{32{b[31]}}, b});
    sa = a;
    sb = b;
    case (o)
      2'b00: return pa * pb;
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Driver: call with the clock low; start is sampled on the next rising edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic with_move, input logic inject);
    int   cyc;
    logic busy_drop;
    logic [63:0] got_exp;
    exp_q.push_back(exp);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    if (with_move) begin
      mtlo       = 1'b1;
      write_data = 32'hDEADBEEF;
    end
    @(posedge clock); #1;
    start     = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    op        = 2'($urandom_range(0, 3));
    cyc       = 0;
    busy_drop = 1'b0;
    while (!done && cyc < 60) begin
      if (!busy) busy_drop = 1'b1;
      if (cyc == 5) check("state_run", 64'(dbg_state), 64'(MDU_RUN));
      if (cyc == 10) begin
        check("hi_hold", 64'(hi), 64'(m_hi));
        check("lo_hold", 64'(lo), 64'(m_lo));
        if (inject) begin
          start      = 1'b1;
          op         = MDU_MULTU;
          operand_a  = 32'd9;
          operand_b  = 32'd9;
          mthi       = 1'b1;
          write_data = 32'h0000AAAA;
        end
      end
      if (cyc == 11) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'd33);
    check("busy_run", 64'(busy_drop), 64'd0);
    got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
    check("result_hi", 64'(hi), 64'(got_exp[63:32]));
    check("result_lo", 64'(lo), 64'(got_exp[31:0]));
    m_hi = got_exp[63:32];
    m_lo = got_exp[31:0];
    @(posedge clock); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clear_n    = 1'b0;
    start      = 1'b0;
    op         = 2'b00;
    operand_a  = '0;
    operand_b  = '0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    write_data = '0;
    m_hi       = '0;
    m_lo       = '0;

    repeat (2) @(posedge clock); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(MDU_IDLE));

    // First start right at reset release.
    @(negedge clock);
    clear_n = 1'b1;
    run_op(MDU_MULT, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 1'b0);
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
    run_op(MDU_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'hFFFFFF9C, 32'd0, 64'hFFFFFF9C_FFFFFFFF, 1'b0, 1'b0);
    run_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
    run_op(MDU_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 1'b0);

    // Start, operands and mthi pulsed mid-run must be ignored.
    run_op(MDU_MULTU, 32'd5, 32'd5, 64'h00000000_00000019, 1'b0, 1'b1);

    // Moves in IDLE.
    @(negedge clock);
    mthi       = 1'b1;
    mtlo       = 1'b1;
    write_data = 32'h00001234;
    @(posedge clock); #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mthi_both", 64'(hi), 64'h1234);
    check("mtlo_both", 64'(lo), 64'h1234);
    check("move_busy", 64'(busy), 64'd0);
    @(negedge clock);
    mthi       = 1'b1;
    write_data = 32'h00005555;
    @(posedge clock); #1;
    mthi = 1'b0;
    check("mthi_only", 64'(hi), 64'h5555);
    check("lo_kept", 64'(lo), 64'h1234);
    m_hi = 32'h00005555;
    m_lo = 32'h00001234;

    // start together with mtlo: only the operation happens.
    @(negedge clock);
    run_op(MDU_MULTU, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b1, 1'b0);

    // Reset in the middle of a DIVU.
    @(negedge clock);
    start     = 1'b1;
    op        = MDU_DIVU;
    operand_a = 32'd10;
    operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(MDU_IDLE));
    @(negedge clock);
    clear_n = 1'b1;
    m_hi    = '0;
    m_lo    = '0;
    run_op(MDU_DIVU, 32'd10, 32'd3, 64'h00000001_00000003, 1'b0, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  r_o;
      logic [31:0] r_a;
      logic [31:0] r_b;
      r_o = 2'($urandom_range(0, 3));
      r_a = $urandom;
      r_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) r_b = -r_b;
      run_op(r_o, r_a, r_b, model(r_o, r_a, r_b), 1'b0, 1'b0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
